spi_slave_tx: RTL and testbench

SPI mode-0 slave transmitter that streams the capture snapshot to the host MCU. It drives the snapshot memory's `latch`, `incr` and `reset_addr` controls, takes the addressed byte on `mem_byte`, and shifts that byte out on MISO, MSB-first. SCK and CS_n come from the MCU and are asynchronous to `clk`. The block oversamples them through synchronizers and runs every action from the resulting edges.

---
 rtl/spi_pkg.sv | 7 +
 rtl/spi_sync_edge.sv | 29 ++
 rtl/spi_slave_tx.sv | 156 +++++++++++++++
 tb/tb_spi_slave_tx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI slave transmitter.
package spi_pkg;
  typedef enum logic [1:0] {IDLE, LATCH, LOAD, SHIFT} spi_state_t;

  localparam int SPI_LENGTH_DEFAULT      = 8;
  localparam int SPI_SYNC_STAGES_DEFAULT = 2;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, with single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Chain and history reset to the pin's idle level so reset never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;
endmodule

// File: rtl/spi_slave_tx.sv
// SPI mode-0 slave transmitter streaming the snapshot memory out on MISO, MSB-first.
// Optional SPI_TX_CHECKSUM_EN appends an XOR checksum byte after every LENGTH data bytes.
module spi_slave_tx import spi_pkg::*; #(
  parameter int LENGTH      = SPI_LENGTH_DEFAULT,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       cs_n,
  input  logic [7:0] mem_byte,
  output logic       miso,
  output logic       miso_oe,
  output logic       mem_latch,
  output logic       mem_incr,
  output logic       mem_reset_addr,
  output logic       busy,
  output logic       frame_done
);
  if (LENGTH < 2 || LENGTH > 255) begin : g_len_chk
    $error("spi_slave_tx: LENGTH must be in 2..255");
  end

  logic sck_rise, sck_fall, cs_rise, cs_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .d(sck), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .d(cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  spi_state_t  state;
  logic [7:0]  tx_shift, next_byte, tx_nxt;
  logic [2:0]  bit_cnt;
  // Prefetch delay: mem_incr -> memory address update -> capture.
  logic [1:0]  vld_pipe;

`ifdef SPI_TX_CHECKSUM_EN
  localparam int              BCW       = $clog2(LENGTH + 1);
  localparam logic [BCW-1:0]  LAST_DATA = BCW'(LENGTH - 1);
  localparam logic [BCW-1:0]  CHK_IDX   = BCW'(LENGTH);
  logic [BCW-1:0] byte_cnt;
  logic [7:0]     chk;
  logic           pf_chk;
`endif

  // A fall after the 8th rise starts the prefetched byte; otherwise shift.
  assign tx_nxt = (bit_cnt == 3'd0) ? next_byte : {tx_shift[6:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      tx_shift       <= '0;
      next_byte      <= '0;
      bit_cnt        <= '0;
      vld_pipe       <= '0;
      miso           <= 1'b0;
      miso_oe        <= 1'b0;
      mem_latch      <= 1'b0;
      mem_incr       <= 1'b0;
      mem_reset_addr <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
`ifdef SPI_TX_CHECKSUM_EN
      byte_cnt       <= '0;
      chk            <= '0;
      pf_chk         <= 1'b0;
`endif
    end else begin
      mem_latch      <= 1'b0;
      mem_incr       <= 1'b0;
      mem_reset_addr <= 1'b0;
      frame_done     <= 1'b0;
      vld_pipe       <= {vld_pipe[0], 1'b0};
      if (cs_rise) begin
        // CS release beats any same-cycle SCK edge and drops a partial byte.
        state          <= IDLE;
        miso           <= 1'b0;
        miso_oe        <= 1'b0;
        busy           <= 1'b0;
        mem_reset_addr <= 1'b1;
        frame_done     <= 1'b1;
        bit_cnt        <= '0;
        vld_pipe       <= '0;
        tx_shift       <= '0;
        next_byte      <= '0;
`ifdef SPI_TX_CHECKSUM_EN
        byte_cnt       <= '0;
        chk            <= '0;
        pf_chk         <= 1'b0;
`endif
      end else begin
        unique case (state)
          IDLE: if (cs_fall) begin
            state     <= LATCH;
            mem_latch <= 1'b1;
            busy      <= 1'b1;
          end
          LATCH: state <= LOAD;
          LOAD: begin
            state    <= SHIFT;
            tx_shift <= mem_byte;
            miso     <= mem_byte[7];
            miso_oe  <= 1'b1;
            bit_cnt  <= '0;
`ifdef SPI_TX_CHECKSUM_EN
            byte_cnt <= '0;
            chk      <= mem_byte;
`endif
          end
          SHIFT: begin
            if (sck_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                vld_pipe <= {vld_pipe[0], 1'b1};
`ifdef SPI_TX_CHECKSUM_EN
                if (byte_cnt == LAST_DATA) begin
                  // Next byte is the checksum: memory address stays put.
                  byte_cnt <= CHK_IDX;
                  pf_chk   <= 1'b1;
                end else begin
                  mem_incr <= 1'b1;
                  pf_chk   <= 1'b0;
                  if (byte_cnt == CHK_IDX) begin
                    byte_cnt <= '0;
                    chk      <= '0;
                  end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                  end
                end
`else
                mem_incr <= 1'b1;
`endif
              end
            end
            if (sck_fall) begin
              tx_shift <= tx_nxt;
              miso     <= tx_nxt[7];
            end
            if (vld_pipe[1]) begin
`ifdef SPI_TX_CHECKSUM_EN
              next_byte <= pf_chk ? chk : mem_byte;
              if (!pf_chk) chk <= chk ^ mem_byte;
`else
              next_byte <= mem_byte;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_tx.sv
// Bench for spi_slave_tx: SPI master + snapshot memory model, table and random frames.
module tb_spi_slave_tx;
  localparam int L = 8;
`ifdef SPI_TX_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic       clk = 1'b0, rst = 1'b1, sck = 1'b0, cs_n = 1'b1;
  logic [7:0] mem_byte;
  logic       miso, miso_oe, mem_latch, mem_incr, mem_reset_addr, busy, frame_done;

  spi_slave_tx #(.LENGTH(L), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .mem_byte(mem_byte),
    .miso(miso), .miso_oe(miso_oe), .mem_latch(mem_latch), .mem_incr(mem_incr),
    .mem_reset_addr(mem_reset_addr), .busy(busy), .frame_done(frame_done)
  );

  always #10 clk = ~clk;

  // Snapshot memory: live values copied on latch; address wraps at L.
  logic [7:0] live [L];
  logic [7:0] snap [L];
  logic [7:0] exp_mem [L];
  logic [2:0] addr;
  assign mem_byte = snap[addr];

  always @(posedge clk or posedge rst) begin
    if (rst) addr <= '0;
    else begin
      if (mem_reset_addr) addr <= '0;
      else if (mem_incr) addr <= (int'(addr) == L-1) ? 3'd0 : addr + 3'd1;
      if (mem_latch) for (int i = 0; i < L; i++) snap[i] <= live[i];
    end
  end

  int n_latch = 0, n_incr = 0, n_rsta = 0, n_done = 0;
  always @(posedge clk) begin
    if (mem_latch)      n_latch <= n_latch + 1;
    if (mem_incr)       n_incr  <= n_incr + 1;
    if (mem_reset_addr) n_rsta  <= n_rsta + 1;
    if (frame_done)     n_done  <= n_done + 1;
  end

  int nvec = 0, nerr = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Expected stream: data bytes repeat every L, with a checksum byte after each L when enabled.
  function automatic logic [7:0] ref_byte(input int k);
    logic [7:0] x;
    x = '0;
    if (CK == 1 && (k % (L+1)) == L) begin
      for (int i = 0; i < L; i++) x ^= exp_mem[i];
      return x;
    end
    return exp_mem[(CK == 1) ? k % (L+1) : k % L];
  endfunction

  function automatic int ref_incr(input int n);
    int c;
    c = 0;
    for (int k = 0; k < n; k++) if (!(CK == 1 && (k % (L+1)) == L-1)) c++;
    return c;
  endfunction

  logic [7:0] rx [16];
  int         rx_n;
  bit         scramble = 1'b0;

  task automatic xfer(input int nbytes, input int abort_rises, input int half);
    int         rises;
    bit         stop;
    logic [7:0] b;
    rises = 0; stop = 1'b0; rx_n = 0;
    @(negedge clk) cs_n = 1'b0;
    repeat (8) @(negedge clk);
    if (scramble) for (int i = 0; i < L; i++) live[i] = 8'($urandom);
    for (int k = 0; k < nbytes && !stop; k++) begin
      b = '0;
      for (int i = 0; i < 8 && !stop; i++) begin
        b = {b[6:0], miso};
        sck = 1'b1; rises++;
        repeat (half) @(negedge clk);
        if (rises == 1) check("active", {busy, miso_oe}, 2'b11);
        sck = 1'b0;
        repeat (half) @(negedge clk);
        if (abort_rises != 0 && rises == abort_rises) stop = 1'b1;
      end
      if (!stop) begin rx[k] = b; rx_n = k + 1; end
    end
    cs_n = 1'b1;
    if (abort_rises != 0) begin
      repeat (3) @(posedge clk);
      #1 check("abort_oe", miso_oe, 1'b0);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic run_frame(input int nbytes, input int abort_rises, input int half,
                           input int exp_incr, input bit chk_first, input logic [7:0] exp_first);
    int l0, i0, r0, d0;
    l0 = n_latch; i0 = n_incr; r0 = n_rsta; d0 = n_done;
    xfer(nbytes, abort_rises, half);
    if (abort_rises == 0) check("rx_count", rx_n, nbytes);
    for (int k = 0; k < rx_n; k++) check($sformatf("byte%0d", k), rx[k], ref_byte(k));
    if (chk_first) check("first_byte", rx[0], exp_first);
    check("latch_cnt", n_latch - l0, 1);
    check("incr_cnt", n_incr - i0, exp_incr);
    check("rsta_cnt", n_rsta - r0, 1);
    check("done_cnt", n_done - d0, 1);
    check("idle_out", {busy, miso_oe, miso}, 3'b000);
  endtask

  typedef struct { int nbytes; int abort_rises; int exp_incr; logic [7:0] exp_first; } vec_t;
  vec_t tbl [6];

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: no finish after 100000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int i0, l0;
    tbl[0] = '{1,  0, 1,       8'h34};
    tbl[1] = '{8,  0, 8 - CK,  8'h34};
    tbl[2] = '{9,  0, 9 - CK,  8'h34};
    tbl[3] = '{10, 0, 10 - CK, 8'h34};
    tbl[4] = '{1,  3, 0,       8'h34};
    tbl[5] = '{1,  0, 1,       8'h34};
    {live[0], live[1], live[2], live[3], live[4], live[5], live[6], live[7]} =
      64'h34_12_78_56_BC_9A_01_DE;
    for (int i = 0; i < L; i++) begin exp_mem[i] = live[i]; snap[i] = '0; end

    repeat (3) @(negedge clk);
    check("reset_out", {miso, miso_oe, mem_latch, mem_incr, mem_reset_addr, busy, frame_done}, 7'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int t = 0; t < 6; t++)
      run_frame(tbl[t].nbytes, tbl[t].abort_rises, 6, tbl[t].exp_incr,
                tbl[t].abort_rises == 0, tbl[t].exp_first);

    // Reset in the middle of byte 2, then SCK activity with CS high must do nothing.
    @(negedge clk) cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      sck = 1'b1; repeat (6) @(negedge clk);
      sck = 1'b0; repeat (6) @(negedge clk);
    end
    sck = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    #3 rst = 1'b1;
    #1 check("midrst_out", {miso, miso_oe, mem_latch, mem_incr, mem_reset_addr, busy, frame_done}, 7'd0);
    repeat (2) @(negedge clk);
    cs_n = 1'b1; sck = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    i0 = n_incr; l0 = n_latch;
    for (int i = 0; i < 9; i++) begin
      sck = 1'b1; repeat (6) @(negedge clk);
      check("post_rst_oe", {miso_oe, busy}, 2'b00);
      sck = 1'b0; repeat (6) @(negedge clk);
    end
    check("post_rst_incr", n_incr - i0, 0);
    check("post_rst_latch", n_latch - l0, 0);
    run_frame(1, 0, 6, 1, 1'b1, 8'h34);

    // Random memory contents, frame lengths and SCK rates; live memory is
    // scrambled mid-frame so only the latched snapshot may appear on MISO.
    scramble = 1'b1;
    for (int r = 0; r < 8; r++) begin
      int n, h;
      for (int i = 0; i < L; i++) begin live[i] = 8'($urandom); exp_mem[i] = live[i]; end
      n = $urandom_range(1, 12);
      h = $urandom_range(5, 8);
      run_frame(n, 0, h, ref_incr(n), 1'b0, 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
